hazard_scoreboard: RTL and testbench

- Parametrised successor to the fixed E/M/W Tuse/Tnew hazard detector of the P6 pipeline.
- Holds a registered scoreboard of in-flight register writes for DEPTH post-decode stages and issues the D-stage stall.
- Produces per-operand D-stage forward selects.
- Models the mult/div unit's busy window with an internal latency counter instead of external busy/start inputs.

---
 rtl/hazard_scoreboard.sv | 157 +++++++++++++++
 tb/tb_hazard_scoreboard.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: registered scoreboard of in-flight GPR writes for DEPTH
// post-decode stages, plus a HI/LO busy counter. Issues the D-stage stall and
// per-operand forward selects from registered state and D inputs only.

// Per-source hazard check: finds the youngest in-flight writer of addr.
module hazard_src_check #(
  parameter int DEPTH = 3,
  parameter int FW    = $clog2(DEPTH+1)
) (
  input  logic                  use_s,
  input  logic [4:0]            addr,
  input  logic [1:0]            tuse,
  input  logic [DEPTH-1:0]      ent_vld,
  input  logic [DEPTH-1:0][4:0] ent_dst,
  input  logic [DEPTH-1:0][1:0] ent_tnew,
  output logic                  stall,
  output logic [FW-1:0]         fwd
);
  logic          hit;
  logic [1:0]    hit_tnew;
  logic [FW-1:0] hit_idx;

  // Scan oldest to youngest so the lowest-index match wins; older writers
  // of the same register are shadowed.
  always_comb begin
    hit      = 1'b0;
    hit_tnew = 2'd0;
    hit_idx  = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (use_s && addr != 5'd0 && ent_vld[i] && ent_dst[i] == addr) begin
        hit      = 1'b1;
        hit_tnew = ent_tnew[i];
        hit_idx  = FW'(i);
      end
    end
  end

  // Stall if the result arrives after the consumer needs it; forward only a
  // ready value, otherwise leave resolution to later-stage forwarding.
  always_comb begin
    stall = hit && (hit_tnew > tuse);
    fwd   = (hit && hit_tnew == 2'd0) ? hit_idx + FW'(1) : '0;
  end
endmodule

module hazard_scoreboard #(
  parameter int DEPTH    = 3,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int FW       = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [4:0]    rs_d,
  input  logic [4:0]    rt_d,
  input  logic          use_rs,
  input  logic          use_rt,
  input  logic [1:0]    tuse_rs,
  input  logic [1:0]    tuse_rt,
  input  logic          wen_d,
  input  logic [4:0]    dst_d,
  input  logic [1:0]    tnew_d,
  input  logic [1:0]    md_op_d,
  input  logic          flush,
  output logic          stall,
  output logic [FW-1:0] fwd_rs,
  output logic [FW-1:0] fwd_rt,
  output logic          md_busy
);
  localparam int MD_MAX = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int MDW    = $clog2(MD_MAX+1);

  logic [DEPTH-1:0]      ent_vld;
  logic [DEPTH-1:0][4:0] ent_dst;
  logic [DEPTH-1:0][1:0] ent_tnew;
  logic [MDW-1:0]        md_cnt;

  // Operand 0 = rs, operand 1 = rt.
  logic [1:0][4:0]    src_addr;
  logic [1:0]         src_use;
  logic [1:0][1:0]    src_tuse;
  logic [1:0]         src_stall;
  logic [1:0][FW-1:0] src_fwd;
  logic               md_stall;

  assign src_addr = {rt_d, rs_d};
  assign src_use  = {use_rt, use_rs};
  assign src_tuse = {tuse_rt, tuse_rs};

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_src
      hazard_src_check #(.DEPTH(DEPTH), .FW(FW)) u_chk (
        .use_s    (src_use[g]),
        .addr     (src_addr[g]),
        .tuse     (src_tuse[g]),
        .ent_vld  (ent_vld),
        .ent_dst  (ent_dst),
        .ent_tnew (ent_tnew),
        .stall    (src_stall[g]),
        .fwd      (src_fwd[g])
      );
    end
  endgenerate

  // Combine data and HI/LO stalls; only registered state and D inputs feed this.
  always_comb begin
    md_busy  = (md_cnt != '0);
    md_stall = (md_op_d != 2'd0) && md_busy;
    stall    = (|src_stall) | md_stall;
    fwd_rs   = src_fwd[0];
    fwd_rt   = src_fwd[1];
  end

  // Scoreboard shift: age entries toward W, issue D (or a bubble) into E.
  // The W entry falls off; the write-first register file covers that cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent_vld  <= '0;
      ent_dst  <= '0;
      ent_tnew <= '0;
    end else if (flush) begin
      ent_vld  <= '0;
      ent_dst  <= '0;
      ent_tnew <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        ent_vld[i]  <= ent_vld[i-1];
        ent_dst[i]  <= ent_dst[i-1];
        ent_tnew[i] <= (ent_tnew[i-1] != 2'd0) ? ent_tnew[i-1] - 2'd1 : 2'd0;
      end
      if (stall) begin
        ent_vld[0]  <= 1'b0;
        ent_dst[0]  <= 5'd0;
        ent_tnew[0] <= 2'd0;
      end else begin
        ent_vld[0]  <= wen_d && (dst_d != 5'd0);
        ent_dst[0]  <= dst_d;
        ent_tnew[0] <= tnew_d;
      end
    end
  end

  // HI/LO busy window: load on an issuing mult/div, then count down. Flush
  // leaves it alone since an in-flight mult/div cannot be cancelled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_cnt <= '0;
    end else if (!stall && md_op_d == 2'd1) begin
      md_cnt <= MDW'(MULT_LAT);
    end else if (!stall && md_op_d == 2'd2) begin
      md_cnt <= MDW'(DIV_LAT);
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - MDW'(1);
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed vectors with hand-computed expectations.
// Stimulus pushes the expected outputs for each D cycle into a queue; the
// monitor pops and compares on the falling edge.
module tb_hazard_scoreboard;
  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_d, rt_d, dst_d;
  logic       use_rs, use_rt, wen_d, flush;
  logic [1:0] tuse_rs, tuse_rt, tnew_d, md_op_d;
  logic       stall, md_busy;
  logic [1:0] fwd_rs, fwd_rt;

  typedef struct {
    string      tag;
    logic       st;
    logic [1:0] frs;
    logic [1:0] frt;
    logic       mb;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  hazard_scoreboard #(.DEPTH(3), .MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .rs_d    (rs_d),
    .rt_d    (rt_d),
    .use_rs  (use_rs),
    .use_rt  (use_rt),
    .tuse_rs (tuse_rs),
    .tuse_rt (tuse_rt),
    .wen_d   (wen_d),
    .dst_d   (dst_d),
    .tnew_d  (tnew_d),
    .md_op_d (md_op_d),
    .flush   (flush),
    .stall   (stall),
    .fwd_rs  (fwd_rs),
    .fwd_rt  (fwd_rt),
    .md_busy (md_busy)
  );

  always #5 clk = ~clk;

  // Monitor: compare the oldest pending expectation on each falling edge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (stall === e.st && fwd_rs === e.frs && fwd_rt === e.frt && md_busy === e.mb)
        passed++;
      else
        $display("FAIL %s: got stall=%0d fwd_rs=%0d fwd_rt=%0d md_busy=%0d, want stall=%0d fwd_rs=%0d fwd_rt=%0d md_busy=%0d",
                 e.tag, stall, fwd_rs, fwd_rt, md_busy, e.st, e.frs, e.frt, e.mb);
    end
  end

  task automatic drv(input logic [4:0] rs, input logic [4:0] rt,
                     input logic urs, input logic urt,
                     input logic [1:0] trs, input logic [1:0] trt,
                     input logic wen, input logic [4:0] dst, input logic [1:0] tn,
                     input logic [1:0] md, input logic fl);
    rs_d = rs; rt_d = rt; use_rs = urs; use_rt = urt;
    tuse_rs = trs; tuse_rt = trt; wen_d = wen; dst_d = dst;
    tnew_d = tn; md_op_d = md; flush = fl;
  endtask

  task automatic expect_out(input string tag, input logic st, input logic [1:0] frs,
                            input logic [1:0] frt, input logic mb);
    exp_t e;
    e.tag = tag; e.st = st; e.frs = frs; e.frt = frt; e.mb = mb;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    drv(0,0,0,0,0,0,0,0,0,0,0);
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset_state", 0, 0, 0, 0);
    tick();
    reset = 1'b1;

    // Load-use: lw $8 (tnew 2), then addu $9,$8,$1 with tuse 0.
    drv(1,0,1,0,1,0,1,8,2,0,0); expect_out("ld_issue", 0, 0, 0, 0); tick();
    drv(8,1,1,1,0,0,1,9,1,0,0); expect_out("ld_use_s1", 1, 0, 0, 0); tick();
    expect_out("ld_use_s2", 1, 0, 0, 0); tick();
    // Load now in W with tnew 0.
    expect_out("ld_use_fwd", 0, 3, 0, 0); tick();

    // ALU to branch: addu $3 (tnew 1), beq $3,$0 with tuse 0.
    drv(1,2,1,1,1,1,1,3,1,0,0); expect_out("alu_issue", 0, 0, 0, 0); tick();
    drv(3,0,1,1,0,0,0,0,0,0,0); expect_out("br_stall", 1, 0, 0, 0); tick();
    expect_out("br_fwd", 0, 2, 0, 0); tick();

    // ALU to store data: sw rt=$3 with tuse 2 right behind addu $3.
    drv(1,2,1,1,1,1,1,3,1,0,0); expect_out("alu_issue2", 0, 0, 0, 0); tick();
    drv(4,3,1,1,1,2,0,0,0,0,0); expect_out("sw_defer", 0, 0, 0, 0); tick();
    // rs == rt both reading the ready value in M.
    drv(3,3,1,1,0,0,0,0,0,0,0); expect_out("rs_eq_rt", 0, 2, 2, 0); tick();

    // Shadowing: addu $5 then lw $5; read $5 with tuse 0.
    drv(1,2,1,1,1,1,1,5,1,0,0); expect_out("sh_addu", 0, 0, 0, 0); tick();
    drv(6,0,1,0,1,0,1,5,2,0,0); expect_out("sh_lw", 0, 0, 0, 0); tick();
    drv(5,7,1,1,0,0,0,0,0,0,0); expect_out("shadow_s1", 1, 0, 0, 0); tick();
    expect_out("shadow_s2", 1, 0, 0, 0); tick();
    expect_out("shadow_fwd", 0, 3, 0, 0); tick();

    // $0 is never tracked.
    drv(1,2,1,1,1,1,1,0,1,0,0); expect_out("r0_write", 0, 0, 0, 0); tick();
    drv(0,0,1,1,0,0,0,0,0,0,0); expect_out("r0_read", 0, 0, 0, 0); tick();

    // Flush: lw $8 in E, flush cycle also tries to issue a $8 writer.
    drv(1,0,1,0,1,0,1,8,2,0,0); expect_out("fl_lw", 0, 0, 0, 0); tick();
    drv(0,0,0,0,0,0,1,8,1,0,1); expect_out("flush_cyc", 0, 0, 0, 0); tick();
    drv(8,8,1,1,0,0,0,0,0,0,0); expect_out("post_flush", 0, 0, 0, 0); tick();

    // Divide window: mflo held for DIV_LAT cycles.
    drv(1,2,1,1,1,1,0,0,0,2,0); expect_out("div_issue", 0, 0, 0, 0); tick();
    drv(0,0,0,0,0,0,1,9,1,3,0);
    for (int k = 0; k < 10; k++) begin
      expect_out($sformatf("md_hold%0d", k), 1, 0, 0, 1); tick();
    end
    expect_out("md_release", 0, 0, 0, 0); tick();

    // Multiply then mid-run reset.
    drv(1,2,1,1,1,1,0,0,0,1,0); expect_out("mult_issue", 0, 0, 0, 0); tick();
    drv(0,0,0,0,0,0,1,10,1,3,0); expect_out("mult_hold", 1, 0, 0, 1); tick();
    reset = 1'b0;
    expect_out("rst_mid", 0, 0, 0, 0); tick();
    expect_out("rst_held", 0, 0, 0, 0); tick();
    reset = 1'b1;
    expect_out("rst_rel", 0, 0, 0, 0); tick();
    drv(0,0,0,0,0,0,0,0,0,0,0);

    // Drain: the monitor must consume everything within a few cycles.
    repeat (4) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
